// File: rtl/exe_unit.sv
// Execute stage: single-cycle ALU/branch/jump ops plus an iterative restoring divider.
// All outputs are registered; a valid/ready handshake stalls upstream while dividing.
module exe_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DIV_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      optype,
  input  logic            use_imm,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] ins_addr,
  output logic            out_valid,
  output logic            write_reg,
  output logic [XLEN-1:0] res,
  output logic            jmp_en,
  output logic [XLEN-1:0] jmp_addr,
  output logic            clr
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_AND   = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL  = 5'd5,  OP_SRL   = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9,  OP_LUI   = 5'd10, OP_AUIPC = 5'd11;
  localparam logic [4:0] OP_JAL = 5'd12, OP_JALR = 5'd13, OP_BEQ   = 5'd14, OP_BNE  = 5'd15;
  localparam logic [4:0] OP_BLT = 5'd16, OP_BGE  = 5'd17, OP_BLTU  = 5'd18, OP_BGEU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM   = 5'd22, OP_REMU = 5'd23;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [XLEN-1:0]    dvsr;
  logic [XLEN-1:0]    quot_r;
  logic [XLEN-1:0]    rem_r;
  logic               q_neg;
  logic               r_neg;
  logic               is_rem;
  logic               spec;
  logic [XLEN-1:0]    spec_val;

  logic [XLEN-1:0]    op_b;
  logic [XLEN-1:0]    alu_res;
  logic               alu_wr;
  logic               alu_jmp;
  logic [XLEN-1:0]    alu_jaddr;
  logic               alu_div;
  logic               taken;

  assign op_b = use_imm ? immediate : data2;

  // Single-cycle result, write enable and redirect for the offered instruction
  always_comb begin
    alu_res   = '0;
    alu_wr    = 1'b1;
    alu_jmp   = 1'b0;
    alu_jaddr = ins_addr + offset;
    alu_div   = 1'b0;
    taken     = 1'b0;
    case (optype)
      OP_ADD:   alu_res = data1 + op_b;
      OP_SUB:   alu_res = data1 - op_b;
      OP_AND:   alu_res = data1 & op_b;
      OP_OR:    alu_res = data1 | op_b;
      OP_XOR:   alu_res = data1 ^ op_b;
      OP_SLL:   alu_res = data1 << op_b[SHW-1:0];
      OP_SRL:   alu_res = data1 >> op_b[SHW-1:0];
      OP_SRA:   alu_res = XLEN'($signed(data1) >>> op_b[SHW-1:0]);
      OP_SLT:   alu_res = XLEN'($signed(data1) < $signed(op_b));
      OP_SLTU:  alu_res = XLEN'(data1 < op_b);
      OP_LUI:   alu_res = immediate;
      OP_AUIPC: alu_res = ins_addr + immediate;
      OP_JAL: begin
        alu_res = ins_addr + XLEN'(4);
        alu_jmp = 1'b1;
      end
      OP_JALR: begin
        alu_res   = ins_addr + XLEN'(4);
        alu_jmp   = 1'b1;
        alu_jaddr = (data1 + immediate) & ~XLEN'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        alu_wr = 1'b0;
        case (optype)
          OP_BEQ:  taken = (data1 == data2);
          OP_BNE:  taken = (data1 != data2);
          OP_BLT:  taken = ($signed(data1) < $signed(data2));
          OP_BGE:  taken = ($signed(data1) >= $signed(data2));
          OP_BLTU: taken = (data1 < data2);
          default: taken = (data1 >= data2);
        endcase
        alu_jmp = taken;
      end
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        if (DIV_EN != 0) alu_div = 1'b1;
        else             alu_wr  = 1'b0;
      end
      default: alu_wr = 1'b0;
    endcase
  end

  // Operand preparation for a divide: magnitudes, result signs and special cases
  logic            sgn_op;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] spec_nx;

  always_comb begin
    sgn_op  = ~optype[0];
    a_neg   = sgn_op & data1[XLEN-1];
    b_neg   = sgn_op & op_b[XLEN-1];
    a_mag   = a_neg ? -data1 : data1;
    b_mag   = b_neg ? -op_b : op_b;
    b_zero  = (op_b == '0);
    ovf     = sgn_op & (data1 == MIN_NEG) & (&op_b);
    spec_nx = b_zero ? (optype[1] ? data1 : '1) : (optype[1] ? '0 : data1);
  end

  // One restoring shift-subtract step and the sign-corrected final value
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quot_nx;
  logic [XLEN-1:0] div_res;

  always_comb begin
    trial   = {rem_r, quot_r[XLEN-1]};
    ge      = (trial >= {1'b0, dvsr});
    rem_nx  = ge ? XLEN'(trial - {1'b0, dvsr}) : trial[XLEN-1:0];
    quot_nx = {quot_r[XLEN-2:0], ge};
    if (spec)        div_res = spec_val;
    else if (is_rem) div_res = r_neg ? -rem_nx : rem_nx;
    else             div_res = q_neg ? -quot_nx : quot_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      write_reg <= 1'b0;
      res       <= '0;
      jmp_en    <= 1'b0;
      jmp_addr  <= '0;
      clr       <= 1'b0;
      cnt       <= '0;
      dvsr      <= '0;
      quot_r    <= '0;
      rem_r     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      is_rem    <= 1'b0;
      spec      <= 1'b0;
      spec_val  <= '0;
    end else begin
      out_valid <= 1'b0;
      jmp_en    <= 1'b0;
      clr       <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (in_valid && in_ready) begin
            if (alu_div) begin
              state    <= DIV;
              in_ready <= 1'b0;
              cnt      <= SHW'(XLEN-1);
              dvsr     <= b_mag;
              quot_r   <= a_mag;
              rem_r    <= '0;
              q_neg    <= (a_neg ^ b_neg) & ~b_zero;
              r_neg    <= a_neg;
              is_rem   <= optype[1];
              spec     <= b_zero | ovf;
              spec_val <= spec_nx;
            end else begin
              out_valid <= 1'b1;
              write_reg <= alu_wr;
              jmp_en    <= alu_jmp;
              clr       <= alu_jmp;
              if (alu_wr)  res      <= alu_res;
              if (alu_jmp) jmp_addr <= alu_jaddr;
            end
          end
        end
        DIV: begin
          quot_r <= quot_nx;
          rem_r  <= rem_nx;
          cnt    <= cnt - SHW'(1);
          if (cnt == '0) begin
            state     <= DONE;
            in_ready  <= 1'b1;
            out_valid <= 1'b1;
            write_reg <= 1'b1;
            res       <= div_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_unit.sv
// Scoreboarded bench for exe_unit (XLEN=32): ALU, branches, jumps, divider, handshake, reset abort.
module tb_exe_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  optype = '0;
  logic        use_imm = 1'b0;
  logic [31:0] data1 = '0, data2 = '0, immediate = '0, offset = '0, ins_addr = '0;
  logic        out_valid, write_reg, jmp_en, clr;
  logic [31:0] res, jmp_addr;

  exe_unit #(.XLEN(32), .DIV_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .optype(optype), .use_imm(use_imm), .data1(data1), .data2(data2),
    .immediate(immediate), .offset(offset), .ins_addr(ins_addr),
    .out_valid(out_valid), .write_reg(write_reg), .res(res),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .clr(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic        wr;
    logic        jen;
    logic [31:0] jaddr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  // Reference behaviour of one instruction, written from the ISA semantics
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d2,
                                 input logic ui, input logic [31:0] imm, input logic [31:0] off,
                                 input logic [31:0] pc);
    exp_t e;
    logic [31:0] b;
    logic        ovf;
    b = ui ? imm : d2;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    e.res = '0; e.chk_res = 1'b1; e.wr = 1'b1; e.jen = 1'b0; e.jaddr = pc + off; e.cyc = 0;
    case (op)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a & b;
      5'd3:  e.res = a | b;
      5'd4:  e.res = a ^ b;
      5'd5:  e.res = a << b[4:0];
      5'd6:  e.res = a >> b[4:0];
      5'd7:  e.res = $signed(a) >>> b[4:0];
      5'd8:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      5'd10: e.res = imm;
      5'd11: e.res = pc + imm;
      5'd12: begin e.res = pc + 32'd4; e.jen = 1'b1; end
      5'd13: begin e.res = pc + 32'd4; e.jen = 1'b1; e.jaddr = (a + imm) & 32'hFFFF_FFFE; end
      5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
        e.wr = 1'b0; e.chk_res = 1'b0;
        case (op)
          5'd14:   e.jen = (a == d2);
          5'd15:   e.jen = (a != d2);
          5'd16:   e.jen = ($signed(a) < $signed(d2));
          5'd17:   e.jen = ($signed(a) >= $signed(d2));
          5'd18:   e.jen = (a < d2);
          default: e.jen = (a >= d2);
        endcase
      end
      5'd20: e.res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      5'd21: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: e.res = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      5'd23: e.res = (b == 0) ? a : a % b;
      default: begin e.wr = 1'b0; e.chk_res = 1'b0; end
    endcase
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every out_valid pulse
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_valid: out_valid=1 at cycle %0d, required no pulse", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cyc !== e.cyc) begin n_fail++; $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, e.cyc); end
          n_assert++;
          if (write_reg !== e.wr) begin n_fail++; $display("FAIL write_reg: got %b, required %b", write_reg, e.wr); end
          n_assert++;
          if (jmp_en !== e.jen) begin n_fail++; $display("FAIL jmp_en: got %b, required %b", jmp_en, e.jen); end
          n_assert++;
          if (clr !== e.jen) begin n_fail++; $display("FAIL clr: got %b, required %b", clr, e.jen); end
          if (e.chk_res) begin
            n_assert++;
            if (res !== e.res) begin n_fail++; $display("FAIL res: got %h, required %h", res, e.res); end
          end
          if (e.jen) begin
            n_assert++;
            if (jmp_addr !== e.jaddr) begin n_fail++; $display("FAIL jmp_addr: got %h, required %h", jmp_addr, e.jaddr); end
          end
        end
      end else if (jmp_en || clr) begin
        n_assert++; n_fail++;
        $display("FAIL idle_redirect: jmp_en=%b clr=%b while out_valid=0, required 0", jmp_en, clr);
      end
    end
  end

  // Offer one instruction at a negedge, wait for acceptance, expect its result
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d2,
                      input logic ui, input logic [31:0] imm, input logic [31:0] off,
                      input logic [31:0] pc);
    exp_t e;
    int w = 0;
    optype = op; data1 = a; data2 = d2; use_imm = ui; immediate = imm; offset = off; ins_addr = pc;
    in_valid = 1'b1;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_assert++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
      in_valid = 1'b0;
      return;
    end
    e = model(op, a, d2, ui, imm, off, pc);
    e.cyc = cyc + ((op >= 5'd20 && op <= 5'd23) ? 33 : 1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_assert++;
    if ({out_valid, write_reg, jmp_en, clr} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 0000", {out_valid, write_reg, jmp_en, clr});
    end
    n_assert++;
    if (res !== 32'd0 || jmp_addr !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: res=%h jmp_addr=%h, required 0", res, jmp_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_alu();
    send(5'd0, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 32'd0);
    drain();
    for (int i = 0; i < 12; i++) begin
      send(5'(i), 32'hF000_1234, 32'h0000_0024, 1'b0, 32'hFFFF_FFF8, 32'd0, 32'h400);
      send(5'(i), 32'h0000_0003, 32'h8000_0000, 1'b1, 32'hFFFF_FFFD, 32'd0, 32'h800);
    end
    send(5'd24, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    send(5'd31, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    drain();
  endtask

  task automatic test_branch();
    send(5'd15, 32'd1, 32'd2, 1'b0, 32'd0, 32'h20, 32'h100);
    send(5'd15, 32'd3, 32'd3, 1'b0, 32'd0, 32'h20, 32'h100);
    for (int op = 14; op < 20; op++) begin
      send(5'(op), 32'hFFFF_FFFE, 32'd5, 1'b0, 32'd0, 32'hFFFF_FFF0, 32'h300);
      send(5'(op), 32'd5, 32'hFFFF_FFFE, 1'b0, 32'd0, 32'h40, 32'h300);
      send(5'(op), 32'd9, 32'd9, 1'b1, 32'd1, 32'h8, 32'h300);
    end
    drain();
  endtask

  task automatic test_jump();
    send(5'd13, 32'h1003, 32'd0, 1'b0, 32'h4, 32'd0, 32'h200);
    send(5'd12, 32'd0, 32'd0, 1'b0, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFC);
    drain();
  endtask

  task automatic test_div();
    int n = 0;
    send(5'd20, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    n_assert++;
    if (n !== 32) begin n_fail++; $display("FAIL div_stall: in_ready low %0d cycles, required 32", n); end
    send(5'd22, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    send(5'd0, 32'd100, 32'd23, 1'b0, 32'd0, 32'd0, 32'd0);
    send(5'd21, 32'd9, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    send(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 32'd0);
    send(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 32'd0);
    send(5'd22, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    drain();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i < 4) ? ($urandom & 32'h0000_FFFF) | 32'h1 : $urandom;
      send(5'(20 + (i % 4)), a, b, 1'b0, 32'd0, 32'd0, 32'd0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      send(5'($urandom_range(0, 19)), $urandom, $urandom, 1'($urandom), $urandom, $urandom, $urandom);
    end
    drain();
  endtask

  task automatic test_reset_mid_div();
    int ok = 1;
    optype = 5'd20; data1 = 32'd1000; data2 = 32'd7; use_imm = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      #1;
      if (out_valid !== 1'b0) ok = 0;
      @(negedge clk);
    end
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL reset_abort: out_valid seen during reset, required 0"); end
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b, required 1", in_ready); end
    repeat (40) @(negedge clk);
    send(5'd0, 32'd20, 32'd22, 1'b0, 32'd0, 32'd0, 32'd0);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_unit.md
Name: exe_unit

Overview:
- Parametrised execute stage for the RV32/RV64 integer core. Sits between decode/register-read and the memory/writeback stage.
- Adds three things over the previous single-cycle execute path:
  - a valid/ready input handshake;
  - a multi-cycle iterative divider (DIV/DIVU/REM/REMU);
  - configurable data width.
- All outputs are registered. Loads and stores are out of scope and are handled by the downstream memory stage.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- DIV_EN, 1, 1 = divider present; 0 = opcodes 20..23 are treated as illegal.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  unit can accept an instruction this cycle.
- optype  input  5  operation code (see Behaviour).
- use_imm  input  1  ALU operand b = immediate (else data2).
- data1  input  XLEN  rs1 value.
- data2  input  XLEN  rs2 value.
- immediate  input  XLEN  sign-extended immediate.
- offset  input  XLEN  branch/JAL offset.
- ins_addr  input  XLEN  instruction PC.
- out_valid  output  1  one-cycle pulse; result fields valid.
- write_reg  output  1  result must be written to rd.
- res  output  XLEN  result value.
- jmp_en  output  1  redirect fetch to jmp_addr.
- jmp_addr  output  XLEN  redirect target.
- clr  output  1  flush younger instructions (mispredict).

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid, write_reg, jmp_en and clr are 0; res and jmp_addr are 0.
  - FSM goes to IDLE; in_ready is 1 once rst is released.
- Accept: an instruction is accepted on a rising edge where in_valid=1 and in_ready=1. Input fields are sampled at that edge only.
- Operand b = use_imm ? immediate : data2.
- Opcodes, with res and write_reg=1 unless noted:
  - 0 ADD a+b.
  - 1 SUB a-b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL a<<b[log2(XLEN)-1:0].
  - 6 SRL.
  - 7 SRA.
  - 8 SLT signed, result 0/1.
  - 9 SLTU.
  - 10 LUI: res=immediate.
  - 11 AUIPC: res=ins_addr+immediate.
  - 12 JAL: res=ins_addr+4; jmp_addr=ins_addr+offset; jmp_en=1.
  - 13 JALR: res=ins_addr+4; jmp_addr=(data1+immediate)&~1; jmp_en=1.
  - 14..19 BEQ, BNE, BLT, BGE, BLTU, BGEU:
    - compare data1 vs data2; write_reg=0;
    - if taken: jmp_en=1, jmp_addr=ins_addr+offset.
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code is illegal: out_valid still pulses, with write_reg=0, jmp_en=0, clr=0.
- Prediction: static not-taken, so clr=jmp_en on the same out_valid cycle.
- Arithmetic is modulo 2^XLEN; carries are discarded. Addresses add in XLEN bits.
- Single-cycle ops:
  - in_ready stays 1.
  - Results appear with out_valid=1 on the cycle after the accept edge (latency 1).
  - Back-to-back accepts give back-to-back out_valid.
- FSM states: IDLE, DIV, DONE.
  - IDLE: accepting a div op loads the operands, converts signed operands to magnitudes, records the result sign, and moves to DIV. in_ready=0 from the following cycle.
  - DIV: restoring shift-subtract, one quotient bit per cycle, counter runs XLEN-1..0. When the counter reaches 0, move to DONE.
  - DONE: apply sign correction, register res, pulse out_valid with write_reg=1, return to IDLE. in_ready=1 in the DONE cycle, so a new instruction can be accepted on that edge.
  - Div latency: out_valid occurs XLEN+1 cycles after the accept edge (33 for XLEN=32).
- Divide special cases, resolved in the accept cycle with the same XLEN+1 latency (keeps timing deterministic):
  - divisor 0: quotient all-ones; remainder = dividend.
  - signed overflow (most-negative / -1): quotient = dividend; remainder 0.
- Sign rules:
  - remainder takes the dividend's sign;
  - quotient is negative iff the operand signs differ and the divisor is non-zero.
- Outputs other than out_valid hold their last value between pulses. jmp_en and clr are 0 whenever out_valid=0.
- Reset asserted mid-division aborts the operation immediately: no out_valid pulse, IDLE on release.

Test Plan:
- Reset, then ADD data1=5, data2=7, use_imm=0 -> next cycle out_valid=1, res=12, write_reg=1, jmp_en=0, clr=0.
- BNE data1=1, data2=2, ins_addr=0x100, offset=0x20 -> out_valid=1, write_reg=0, jmp_en=1, clr=1, jmp_addr=0x120. With data1=data2=3 -> jmp_en=0, clr=0.
- JALR data1=0x1003, immediate=0x4, ins_addr=0x200 -> res=0x204, jmp_addr=0x1006, jmp_en=1.
- DIV data1=-7, data2=2 (XLEN=32):
  - in_ready=0 for the DIV cycles; out_valid exactly 33 cycles after accept with res=0xFFFFFFFD.
  - REM with the same operands -> res=0xFFFFFFFF.
  - Held ADD offered during DIV is accepted on the DONE edge and produces its result the next cycle.
- DIVU by 0 with data1=9 -> res=0xFFFFFFFF. REM 0x80000000 by -1 -> res=0. Both at 33-cycle latency.
- Start DIV, drop rst at cycle 10 for 2 cycles -> no out_valid; in_ready=1 after release; the next ADD completes in 1 cycle.
